// File: rtl/host_disp_pkg.sv
// host_disp_pkg: shared state encoding, ASCII constants and letter folding for the host display
package host_disp_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_UNDER = 8'h5F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam logic [2:0][7:0] WIN_STR  = "WIN";
    localparam logic [3:0][7:0] LOSE_STR = "LOSE";

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= "a" && c <= "z") ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/host_disp_hist.sv
// host_disp_hist: miss-history shift register, newest miss in slot 0, with membership compare
module host_disp_hist
    import host_disp_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic [7:0]            probe,
    output logic [DEPTH-1:0][7:0] slots,
    output logic                  hit
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slots <= {DEPTH{ASCII_SPACE}};
        end else if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) slots[i] <= slots[i-1];
            slots[0] <= din;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) hit = hit | (slots[i] == probe);
    end

endmodule

// File: rtl/host_disp_gen.sv
// host_disp_gen: guessing-game state, two-row ASCII render and valid/ready frame hand-off to the LCD driver
module host_disp_gen
    import host_disp_pkg::*;
#(
    parameter int WORD_LEN   = 5,
    parameter int MAX_MISS   = 6,
    parameter int HIST_DEPTH = 6,
    parameter int COLS       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            game_end,
    input  logic                            guess_valid,
    input  logic [7:0]                      letter,
    input  logic [WORD_LEN-1:0]             index_correct,
    input  logic [8*WORD_LEN-1:0]           word,
    output logic [8*COLS-1:0]               top,
    output logic [8*COLS-1:0]               bottom,
    output logic                            disp_valid,
    input  logic                            disp_ready,
    output logic                            dup_guess,
    output logic                            won,
    output logic                            lost,
    output logic [$clog2(MAX_MISS+1)-1:0]   miss_cnt
);

    localparam int PAD = (COLS - WORD_LEN) / 2;
    localparam int MW  = $clog2(MAX_MISS + 1);

    state_t                         state, state_n;
    logic [WORD_LEN-1:0][7:0]       rev, rev_n, secret;
    logic [HIST_DEPTH-1:0][7:0]     hist;
    logic [COLS-1:0][7:0]           r_top, r_bot;
    logic [MW-1:0]                  miss_n;
    logic [7:0]                     lf;
    logic                           in_word, hist_hit, dup, play_g, miss, done, dirty, chg;

    assign secret = word;
    assign lf     = to_upper(letter);
    assign play_g = guess_valid && state == PLAY && !game_end && !start;
    assign dup    = in_word || hist_hit;
    assign miss   = play_g && !dup && index_correct == '0;
    assign won    = state == WIN;
    assign lost   = state == LOSE;
    assign chg    = state_n != state || rev_n != rev || miss_n != miss_cnt;

    host_disp_hist #(.DEPTH(HIST_DEPTH)) u_hist (
        .clk   (clk),
        .rst   (rst),
        .clr   (game_end || start),
        .push  (miss),
        .din   (lf),
        .probe (lf),
        .slots (hist),
        .hit   (hist_hit)
    );

    always_comb begin
        in_word = 1'b0;
        done    = 1'b1;
        rev_n   = rev;
        state_n = state;
        miss_n  = miss_cnt;
        for (int i = 0; i < WORD_LEN; i++) in_word = in_word | (rev[i] == lf);
        if (game_end || start) begin
            state_n = game_end ? IDLE : PLAY;
            rev_n   = {WORD_LEN{ASCII_UNDER}};
            miss_n  = '0;
        end else if (play_g && !dup && index_correct != '0) begin
            for (int i = 0; i < WORD_LEN; i++)
                if (index_correct[i] && rev[i] == ASCII_UNDER) rev_n[i] = lf;
            for (int i = 0; i < WORD_LEN; i++) done = done & (rev_n[i] != ASCII_UNDER);
            state_n = done ? WIN : PLAY;
        end else if (miss) begin
            miss_n  = miss_cnt + 1'b1;
            state_n = (miss_n == MW'(MAX_MISS)) ? LOSE : PLAY;
        end
    end

    // Row byte COLS-1 is column 0, so column c lives at index COLS-1-c.
    always_comb begin
        r_top = {COLS{ASCII_SPACE}};
        r_bot = {COLS{ASCII_SPACE}};
        if (state == PLAY) begin
            for (int i = 0; i < WORD_LEN; i++) r_top[COLS-1-PAD-i] = rev[WORD_LEN-1-i];
            for (int i = 0; i < HIST_DEPTH; i++) r_bot[COLS-1-i] = hist[i];
            r_bot[0] = ASCII_ZERO + 8'(MAX_MISS) - 8'(miss_cnt);
        end
        if (state == WIN || state == LOSE)
            for (int i = 0; i < WORD_LEN; i++) r_bot[COLS-1-PAD-i] = secret[WORD_LEN-1-i];
        if (state == WIN)
            for (int i = 0; i < 3; i++) r_top[COLS-1-PAD-i] = WIN_STR[2-i];
        if (state == LOSE)
            for (int i = 0; i < 4; i++) r_top[COLS-1-PAD-i] = LOSE_STR[3-i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rev        <= {WORD_LEN{ASCII_UNDER}};
            miss_cnt   <= '0;
            dup_guess  <= 1'b0;
            dirty      <= 1'b1;
            disp_valid <= 1'b0;
            top        <= {COLS{ASCII_SPACE}};
            bottom     <= {COLS{ASCII_SPACE}};
        end else begin
            state     <= state_n;
            rev       <= rev_n;
            miss_cnt  <= miss_n;
            dup_guess <= play_g && dup;
            if (dirty && (!disp_valid || disp_ready)) begin
                top        <= r_top;
                bottom     <= r_bot;
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
            // A change landing in the same cycle as a load keeps dirty so it is sent next.
            dirty <= chg || (dirty && disp_valid && !disp_ready);
        end
    end

endmodule

// File: tb/tb_host_disp_gen.sv
// tb_host_disp_gen: directed and randomized checks of host_disp_gen against a game-level reference model
module tb_host_disp_gen;

    localparam int WL  = 5;
    localparam int MM  = 6;
    localparam int HD  = 6;
    localparam int C   = 16;
    localparam int PAD = (C - WL) / 2;

    logic            clk = 1'b0;
    logic            rst, start, game_end, guess_valid, disp_ready;
    logic            disp_valid, dup_guess, won, lost;
    logic [7:0]      letter;
    logic [WL-1:0]   index_correct;
    logic [8*WL-1:0] word;
    logic [8*C-1:0]  top, bottom;
    logic [2:0]      miss_cnt;

    always #5 clk = ~clk;

    host_disp_gen #(.WORD_LEN(WL), .MAX_MISS(MM), .HIST_DEPTH(HD), .COLS(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .game_end      (game_end),
        .guess_valid   (guess_valid),
        .letter        (letter),
        .index_correct (index_correct),
        .word          (word),
        .top           (top),
        .bottom        (bottom),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .dup_guess     (dup_guess),
        .won           (won),
        .lost          (lost),
        .miss_cnt      (miss_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    int frames = 0;
    logic [8*C-1:0] last_top, last_bot;

    // model: 0 idle, 1 play, 2 win, 3 lose; column k of the word is m_sec[k]
    int         m_state = 0;
    int         m_miss = 0;
    logic [7:0] m_sec[WL];
    logic [7:0] m_rev[WL];
    logic [7:0] m_hist[$];

    always @(negedge clk)
        if (disp_valid && disp_ready) begin
            frames++;
            last_top = top;
            last_bot = bottom;
        end

    task automatic chk(input string tag, input logic [8*C-1:0] obs, input logic [8*C-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] up(input logic [7:0] c);
        return (c >= "a" && c <= "z") ? c - 8'h20 : c;
    endfunction

    function automatic logic [16*C-1:0] exp_frame();
        logic [7:0] t[C];
        logic [7:0] b[C];
        logic [16*C-1:0] res;
        string s;
        for (int c = 0; c < C; c++) begin
            t[c] = " ";
            b[c] = " ";
        end
        if (m_state == 1) begin
            for (int k = 0; k < WL; k++) t[PAD+k] = m_rev[k];
            for (int k = 0; k < m_hist.size() && k < HD; k++) b[k] = m_hist[k];
            b[C-1] = 8'(48 + MM - m_miss);
        end else if (m_state >= 2) begin
            s = (m_state == 2) ? "WIN" : "LOSE";
            for (int k = 0; k < s.len(); k++) t[PAD+k] = s[k];
            for (int k = 0; k < WL; k++) b[PAD+k] = m_sec[k];
        end
        for (int c = 0; c < C; c++) begin
            res[16*C-1-8*c -: 8] = t[c];
            res[8*C-1-8*c -: 8]  = b[c];
        end
        return res;
    endfunction

    task automatic clear_model;
        for (int k = 0; k < WL; k++) m_rev[k] = "_";
        m_hist.delete();
        m_miss = 0;
    endtask

    task automatic set_word(input logic [8*WL-1:0] w);
        word = w;
        for (int k = 0; k < WL; k++) m_sec[k] = w[8*(WL-1-k) +: 8];
    endtask

    // One control cycle; checks flags one edge later, then valid and the delivered frame with ready high.
    task automatic op(input string tag, input bit st, input bit ge, input bit gv,
                      input logic [7:0] l, input bit fchk);
        logic [7:0]      lu;
        logic [WL-1:0]   idx;
        logic [16*C-1:0] f;
        bit              chg, dup, hit, full;
        int              f0;
        lu = up(l);
        chg = 0; dup = 0; hit = 0; idx = '0;
        for (int k = 0; k < WL; k++)
            if (m_sec[k] == lu) begin
                idx[WL-1-k] = 1'b1;
                hit = 1;
            end
        if (ge) begin
            chg = m_state != 0;
            m_state = 0;
            clear_model();
        end else if (st) begin
            chg = m_state != 1 || m_miss != 0;
            for (int k = 0; k < WL; k++) if (m_rev[k] != "_") chg = 1;
            m_state = 1;
            clear_model();
        end else if (gv && m_state == 1) begin
            for (int k = 0; k < WL; k++) if (m_rev[k] == lu) dup = 1;
            foreach (m_hist[i]) if (m_hist[i] == lu) dup = 1;
            if (!dup) begin
                chg = 1;
                if (hit) begin
                    for (int k = 0; k < WL; k++) if (m_sec[k] == lu) m_rev[k] = lu;
                    full = 1;
                    for (int k = 0; k < WL; k++) if (m_rev[k] == "_") full = 0;
                    if (full) m_state = 2;
                end else begin
                    m_hist.push_front(lu);
                    m_miss++;
                    if (m_miss == MM) m_state = 3;
                end
            end
        end
        f0 = frames;
        tick;
        start = st; game_end = ge; guess_valid = gv; letter = l; index_correct = idx;
        tick;
        start = 0; game_end = 0; guess_valid = 0;
        chk({tag, ":dup_guess"}, dup_guess, dup);
        chk({tag, ":miss_cnt"}, miss_cnt, m_miss);
        chk({tag, ":won"}, won, m_state == 2);
        chk({tag, ":lost"}, lost, m_state == 3);
        tick;
        chk({tag, ":dup_pulse_end"}, dup_guess, 0);
        if (fchk) chk({tag, ":disp_valid"}, disp_valid, chg);
        tick;
        if (fchk) begin
            chk({tag, ":frames"}, frames - f0, chg);
            if (chg) begin
                f = exp_frame();
                chk({tag, ":top"}, last_top, f[16*C-1 -: 8*C]);
                chk({tag, ":bottom"}, last_bot, f[8*C-1:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [16*C-1:0]  e1;
        logic [8*C-1:0]   snap_t, snap_b, blank;
        logic [8*WL-1:0]  w;
        logic [7:0]       l;
        int               f0;
        blank = {C{8'h20}};
        rst = 1; start = 0; game_end = 0; guess_valid = 0; letter = 0;
        index_correct = '0; disp_ready = 1;
        set_word("APPLE");
        clear_model();
        tick; tick; tick;
        chk("rst:top", top, blank);
        chk("rst:bottom", bottom, blank);
        chk("rst:disp_valid", disp_valid, 0);
        chk("rst:miss_cnt", miss_cnt, 0);
        chk("rst:won_lost", {won, lost, dup_guess}, 0);
        f0 = frames;
        rst = 0;
        tick;
        chk("rst:first_frame_valid", disp_valid, 1);
        tick;
        chk("rst:frames", frames - f0, 1);
        chk("rst:frame_top", last_top, blank);

        op("t1_start", 1, 0, 0, 0, 1);
        op("t2_hit_p", 0, 0, 1, "p", 1);
        op("t2_dup_P", 0, 0, 1, "P", 1);
        op("t3_miss_z", 0, 0, 1, "z", 1);
        op("t3_miss_x", 0, 0, 1, "X", 1);
        op("t3_miss_q", 0, 0, 1, "q", 1);
        op("t3_miss_w", 0, 0, 1, "W", 1);
        op("t3_miss_r", 0, 0, 1, "r", 1);
        op("t3_miss_t", 0, 0, 1, "T", 1);
        op("t3_ignored", 0, 0, 1, "A", 1);

        op("t4_start", 1, 0, 0, 0, 1);
        op("t4_a", 0, 0, 1, "A", 1);
        op("t4_p", 0, 0, 1, "p", 1);
        op("t4_l", 0, 0, 1, "L", 1);
        op("t4_e", 0, 0, 1, "e", 1);

        op("t5_start", 1, 0, 0, 0, 1);
        f0 = frames;
        disp_ready = 0;
        op("t5_stall_z", 0, 0, 1, "Z", 0);
        e1 = exp_frame();
        op("t5_stall_x", 0, 0, 1, "x", 0);
        op("t5_stall_q", 0, 0, 1, "Q", 0);
        snap_t = top;
        snap_b = bottom;
        chk("t5:held_top", snap_t, e1[16*C-1 -: 8*C]);
        chk("t5:held_bottom", snap_b, e1[8*C-1:0]);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t5:frozen_top", top, snap_t);
            chk("t5:frozen_bottom", bottom, snap_b);
            chk("t5:valid_held", disp_valid, 1);
        end
        disp_ready = 1;
        tick; tick; tick; tick;
        e1 = exp_frame();
        chk("t5:frames_after_release", frames - f0, 2);
        chk("t5:coalesced_top", last_top, e1[16*C-1 -: 8*C]);
        chk("t5:coalesced_bottom", last_bot, e1[8*C-1:0]);
        chk("t5:valid_drop", disp_valid, 0);

        op("t6_end_and_guess", 0, 1, 1, "b", 1);

        for (int r = 0; r < 30; r++) begin
            op("rnd_end", 0, 1, 0, 0, 1);
            for (int k = 0; k < WL; k++) w[8*k +: 8] = 8'("A" + $urandom_range(0, 7));
            set_word(w);
            op("rnd_start", 1, 0, 0, 0, 1);
            for (int g = 0; g < 30 && m_state == 1; g++) begin
                l = ($urandom_range(0, 1) == 0) ? m_sec[$urandom_range(0, WL-1)]
                                                : 8'("A" + $urandom_range(0, 11));
                if ($urandom_range(0, 1) == 0) l = l + 8'h20;
                if ($urandom_range(0, 49) == 0) op("rnd_abort", 0, 1, 1, l, 1);
                else op("rnd_guess", 0, 0, 1, l, 1);
            end
            op("rnd_post", 0, 0, 1, "A", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
